// File: rtl/param_dual_port_ram.sv
// ---------------------------------------------------------------------------
// param_dual_port_ram
//   Two-port, single-clock RAM. Each port can write and read in the same
//   cycle. Reset starts a clear sequence that zeroes every word, one address
//   per cycle. Port traffic is ignored until the clear has finished.
//
// Parameters
//   DATA_W    word width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   RDW_MODE  same-address read during write: 0 = old data, 1 = new data
//
// Ports
//   clk                          rising-edge clock
//   rst                          synchronous, active-high reset
//   data_pN/addr_pN/wr_pN/rd_pN  port N write data, address, write enable,
//                                read enable
//   out_pN/vld_pN                port N registered read data and valid strobe
//   collision                    one-cycle pulse after a same-address dual
//                                write; port 1 data is the one stored
//   busy                         high while the clear sequence runs
//
// Compile-time option
//   PIPE_OUT_EN  when defined, adds one output register stage to out_pN and
//                vld_pN, so read latency goes from 1 to 2.
// ---------------------------------------------------------------------------

// Read return path for one port. Stage 0 captures the read. It holds its
// value when no read is accepted. Any extra stages are plain delay registers.
module dpr_rd_port #(
  parameter int DATA_W = 8,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] out,
  output logic              vld
);
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc;
      if (acc) dat_pipe[0] <= rdata;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign out = dat_pipe[STAGES];
  assign vld = vld_pipe[STAGES];
endmodule

module param_dual_port_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_p1,
  input  logic [ADDR_W-1:0] addr_p1,
  input  logic              wr_p1,
  input  logic              rd_p1,
  input  logic [DATA_W-1:0] data_p2,
  input  logic [ADDR_W-1:0] addr_p2,
  input  logic              wr_p2,
  input  logic              rd_p2,
  output logic [DATA_W-1:0] out_p1,
  output logic              vld_p1,
  output logic [DATA_W-1:0] out_p2,
  output logic              vld_p2,
  output logic              collision,
  output logic              busy
);
  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_PORTS = 2;
`ifdef PIPE_OUT_EN
  localparam int OUT_STAGES = 1;
`else
  localparam int OUT_STAGES = 0;
`endif

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;

  // Two physical write ports. w_hi is committed last, so it wins any address
  // clash: it carries the clear write or port 1. w_lo carries port 2.
  wr_req_t w_hi, w_lo;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
  logic [NUM_PORTS-1:0]             port_rd;
  logic [NUM_PORTS-1:0]             port_acc;
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_rdata;
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_out;
  logic [NUM_PORTS-1:0]             port_vld;

  // Writes and reads presented during the rst cycle are dropped.
  assign idle = (state == S_IDLE) && !rst;

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    if (!rst) begin
      if (state == S_CLEAR) begin
        w_hi.en   = 1'b1;
        w_hi.addr = clr_cnt;
      end else begin
        w_hi.en   = wr_p1;
        w_hi.addr = addr_p1;
        w_hi.data = data_p1;
        // A same-address dual write stores only port 1 data.
        w_lo.en   = wr_p2 && !(wr_p1 && (addr_p1 == addr_p2));
        w_lo.addr = addr_p2;
        w_lo.data = data_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_lo.en) mem[w_lo.addr] <= w_lo.data;
    if (w_hi.en) mem[w_hi.addr] <= w_hi.data;
  end

  assign port_addr = {addr_p2, addr_p1};
  assign port_rd   = {rd_p2, rd_p1};
  assign port_acc  = idle ? port_rd : '0;

  // The array read returns the pre-edge contents, which gives old data.
  // Write-first mode bypasses the data being written this cycle. The w_hi
  // check comes last so that it takes priority.
  always_comb begin
    port_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_rdata[p] = mem[port_addr[p]];
      if (RDW_MODE == 1) begin
        if (w_lo.en && (w_lo.addr == port_addr[p])) port_rdata[p] = w_lo.data;
        if (w_hi.en && (w_hi.addr == port_addr[p])) port_rdata[p] = w_hi.data;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dpr_rd_port #(
      .DATA_W (DATA_W),
      .STAGES (OUT_STAGES)
    ) u_rd (
      .clk   (clk),
      .rst   (rst),
      .acc   (port_acc[p]),
      .rdata (port_rdata[p]),
      .out   (port_out[p]),
      .vld   (port_vld[p])
    );
  end

  assign out_p1 = port_out[0];
  assign vld_p1 = port_vld[0];
  assign out_p2 = port_out[1];
  assign vld_p2 = port_vld[1];

  // Control FSM. The clear counter stops at DEPTH-1. That final write and
  // the move to IDLE happen on the same edge, so CLEAR lasts DEPTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      busy      <= 1'b1;
      collision <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          collision <= 1'b0;
          if (clr_cnt == ADDR_W'(DEPTH-1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          busy      <= 1'b0;
          collision <= wr_p1 && wr_p2 && (addr_p1 == addr_p2);
        end
        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_W, 8, word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- data_p1  in  DATA_W  port 1 write data.
- addr_p1  in  ADDR_W  port 1 address.
- wr_p1  in  1  port 1 write enable.
- rd_p1  in  1  port 1 read enable.
- data_p2  in  DATA_W  port 2 write data.
- addr_p2  in  ADDR_W  port 2 address.
- wr_p2  in  1  port 2 write enable.
- rd_p2  in  1  port 2 read enable.
- out_p1  out  DATA_W  port 1 read data, registered.
- vld_p1  out  1  out_p1 valid strobe.
- out_p2  out  DATA_W  port 2 read data, registered.
- vld_p2  out  1  out_p2 valid strobe.
- collision  out  1  one-cycle pulse on same-address dual write.
- busy  out  1  high while the memory-clear sequence runs.

Function
REQ-003 Each port SHALL independently write and read every cycle; wr and rd asserted together on one port SHALL perform both operations at one address.
REQ-004 A read accepted at edge N SHALL present data on out_pN with vld_pN=1 after edge N+1 (latency 1); vld_pN SHALL be 0 on cycles with no accepted read, and out_pN SHALL then hold its last value.
REQ-005 Reads SHALL obey RDW_MODE for any same-cycle write to the same address, from either port.
REQ-006 If wr_p1 and wr_p2 target the same address in one cycle, port 1 data SHALL be stored, and collision SHALL be 1 for exactly the following cycle.
REQ-007 Writes to different addresses in the same cycle SHALL both complete.
REQ-008 A two-state FSM SHALL control the block:
- CLEAR: a counter writes zero to address 0..DEPTH-1, one address per cycle; busy=1; all port reads and writes are ignored; vld_p1 and vld_p2 stay 0.
- IDLE: normal operation; busy=0.
REQ-009 CLEAR SHALL move to IDLE on the edge after address DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles; IDLE SHALL have no exit other than rst.
REQ-010 Address arithmetic SHALL use ADDR_W bits; the clear counter SHALL not wrap past DEPTH-1.

Reset
REQ-011 rst sampled high SHALL enter CLEAR with the counter at 0, and SHALL set out_p1=0, out_p2=0, vld_p1=0, vld_p2=0, collision=0, busy=1.
REQ-012 rst asserted mid-CLEAR or mid-operation SHALL restart the clear from address 0; any writes presented in the rst cycle SHALL be discarded.

Configuration
REQ-013 Macro PIPE_OUT_EN SHALL be the only compile-time option:
- Defined: an extra output register stage is added to out_pN and vld_pN; read latency becomes 2; the stage resets to 0.
- Undefined: read latency is 1.
RDW_MODE and collision behaviour SHALL be unchanged in both builds.

Verification
Defaults are used in all scenarios; PIPE_OUT_EN is undefined unless stated.
REQ-014 Reset clear: pulse rst for 1 cycle -> busy=1 for 64 cycles then 0; reads of addr 0x00, 0x3F return 0x00.
REQ-015 Basic traffic: write p1 addr 0x01=0x45 and p2 addr 0x02=0x32, then read p2 0x01 and p1 0x02 -> out_p2=0x45, out_p1=0x32 one cycle later with vld=1.
REQ-016 Collision: p1 writes 0x24 and p2 writes 0x10, both at addr 0x03 -> collision=1 for 1 cycle; a later read of 0x03 returns 0x24.
REQ-017 Read-during-write: addr 0x05 holds 0x11; p1 writes 0x99 while p2 reads 0x05 -> out_p2=0x11 with RDW_MODE=0, 0x99 with RDW_MODE=1.
REQ-018 Mid-clear reset and ignore-while-busy: assert rst at clear cycle 30; attempt a write of 0xAA to 0x3F while busy -> busy lasts 64 further cycles; 0x3F reads 0x00; vld stays 0 while busy.
REQ-019 Pipelined build: with PIPE_OUT_EN defined, repeat REQ-015 -> same data, vld_pN arrives 2 cycles after the read.
